// File: rtl/infra_reset_sequencer.sv
// Power-up reset sequencer: pulses MMCM reset, waits for a stable lock, pulses
// IDELAYCTRL reset, waits for RDY, then releases the downstream domain reset.
module infra_reset_sequencer #(
    parameter int RST_HOLD      = 16,
    parameter int LOCK_WAIT     = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int IDLY_TIMEOUT  = 4096,
    parameter int MAX_RETRY     = 3,
    parameter int CNT_W         = 20
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       mmcm_locked,
    input  logic       idelay_rdy,
    input  logic       soft_rst_req,
    output logic       mmcm_rst,
    output logic       idelay_rst,
    output logic       sys_rst,
    output logic       rst_done,
    output logic       fault,
    output logic [3:0] retry_count,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_MMCM_RST  = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_IDLY_RST  = 3'd3,
        S_WAIT_IDLY = 3'd4,
        S_RUN       = 3'd5,
        S_FAULT     = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_WAIT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLY_LAST   = CNT_W'(IDLY_TIMEOUT - 1);
    localparam logic [3:0]       RETRY_LIM   = 4'(MAX_RETRY);

    state_t           cur_state;
    state_t           nxt_state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       retry_nxt;
    logic             cnt_clr;
    logic [1:0]       lock_sync;
    logic [1:0]       rdy_sync;
    logic             lock_s;
    logic             rdy_s;

    // Both status inputs come from other clocking contexts; only the
    // second flop of each chain is allowed to steer the FSM.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            lock_sync <= 2'b00;
            rdy_sync  <= 2'b00;
        end else begin
            lock_sync <= {lock_sync[0], mmcm_locked};
            rdy_sync  <= {rdy_sync[0], idelay_rdy};
        end
    end

    assign lock_s = lock_sync[1];
    assign rdy_s  = rdy_sync[1];
    assign state  = cur_state;

    always_comb begin
        nxt_state = cur_state;
        retry_nxt = retry_count;
        if (soft_rst_req) begin
            nxt_state = S_MMCM_RST;
            retry_nxt = 4'd0;
        end else begin
            case (cur_state)
                S_MMCM_RST: begin
                    if (cnt == HOLD_LAST) nxt_state = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        nxt_state = S_STABLE;
                    end else if (cnt == LOCK_LAST) begin
                        retry_nxt = (retry_count == 4'd15) ? 4'd15 : retry_count + 4'd1;
                        nxt_state = (retry_nxt == RETRY_LIM) ? S_FAULT : S_MMCM_RST;
                    end
                end
                S_STABLE: begin
                    if (!lock_s)                 nxt_state = S_WAIT_LOCK;
                    else if (cnt == STABLE_LAST) nxt_state = S_IDLY_RST;
                end
                S_IDLY_RST: begin
                    if (!lock_s)               nxt_state = S_MMCM_RST;
                    else if (cnt == HOLD_LAST) nxt_state = S_WAIT_IDLY;
                end
                S_WAIT_IDLY: begin
                    // Lock loss wins over a coincident IDELAY timeout.
                    if (!lock_s)               nxt_state = S_MMCM_RST;
                    else if (rdy_s)            nxt_state = S_RUN;
                    else if (cnt == IDLY_LAST) nxt_state = S_FAULT;
                end
                S_RUN: begin
                    if (!lock_s) nxt_state = S_MMCM_RST;
                end
                S_FAULT: nxt_state = S_FAULT;
                default: nxt_state = S_MMCM_RST;
            endcase
        end
        cnt_clr = soft_rst_req || (nxt_state != cur_state);
    end

    // Outputs decode the next state so they change in the same edge as state.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cur_state   <= S_MMCM_RST;
            cnt         <= '0;
            retry_count <= 4'd0;
            mmcm_rst    <= 1'b1;
            idelay_rst  <= 1'b0;
            sys_rst     <= 1'b1;
            rst_done    <= 1'b0;
            fault       <= 1'b0;
        end else begin
            cur_state   <= nxt_state;
            retry_count <= retry_nxt;
            if (cnt_clr)         cnt <= '0;
            else if (cnt != '1)  cnt <= cnt + 1'b1;
            mmcm_rst    <= (nxt_state == S_MMCM_RST);
            idelay_rst  <= (nxt_state == S_IDLY_RST);
            sys_rst     <= (nxt_state != S_RUN);
            rst_done    <= (nxt_state == S_RUN);
            fault       <= (nxt_state == S_FAULT);
        end
    end

endmodule
